// File: rtl/hdmi_blk_pkg.sv
// Shared types and constants for the HDMI-to-8x8-block stripe scheduler.
package hdmi_blk_pkg;

   localparam int BLK_DIM = 8;

   typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;
   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_t;
   typedef enum logic {R_IDLE, R_RUN} rd_state_t;

   function automatic int beats_per_block(input int n);
      return (BLK_DIM * BLK_DIM) / n;
   endfunction

endpackage

// File: rtl/hdmi_stripe_rd_seq.sv
// Block-order read sequencer: walks col/row/blk over one stripe bank and
// produces the block framing flags, delayed one cycle to line up with RAM data.
module hdmi_stripe_rd_seq
   import hdmi_blk_pkg::*;
#(
   parameter int N     = 2,
   parameter int X_RES = 2160,
   parameter int AW    = 7
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          run,
   input  logic          blk_ready,
   input  logic          first,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic          last_issue,
   output logic          blk_valid,
   output logic          blk_sob,
   output logic          blk_eob,
   output logic          blk_sof
);

   localparam int CPR  = BLK_DIM / N;
   localparam int XB   = X_RES / N;
   localparam int NBLK = X_RES / BLK_DIM;
   localparam int BPB  = beats_per_block(N);
   localparam int CW   = (CPR > 1) ? $clog2(CPR) : 1;
   localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1;

   logic [CW-1:0] col;
   logic [2:0]    row;
   logic [BW-1:0] blk;
   logic          col_last, row_last, blk_last;
   logic          sob_c, eob_c, sof_c;

   assign col_last = (int'(col) == CPR - 1);
   assign row_last = (row == 3'd7);
   assign blk_last = (int'(blk) == NBLK - 1);

   assign rd_en      = run & blk_ready & en;
   assign last_issue = rd_en & col_last & row_last & blk_last;
   assign rd_addr    = AW'(int'(row) * XB + int'(blk) * CPR + int'(col));

   assign sob_c = (col == '0) && (row == 3'd0);
   assign eob_c = (int'(row) * CPR + int'(col) == BPB - 1);
   assign sof_c = sob_c && (blk == '0) && first;

   // Column runs fastest, then row inside the block, then block across the stripe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
         blk <= '0;
      end else if (rd_en) begin
         if (col_last) begin
            col <= '0;
            if (row_last) begin
               row <= '0;
               blk <= blk_last ? '0 : blk + 1'b1;
            end else begin
               row <= row + 3'd1;
            end
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Not gated by en so that blk_valid drops the cycle after en goes low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk_valid <= 1'b0;
         blk_sob   <= 1'b0;
         blk_eob   <= 1'b0;
         blk_sof   <= 1'b0;
      end else begin
         blk_valid <= rd_en;
         blk_sob   <= rd_en & sob_c;
         blk_eob   <= rd_en & eob_c;
         blk_sof   <= rd_en & sof_c;
      end
   end

endmodule

// File: rtl/hdmi_stripe_sched.sv
// Raster tracker and ping-pong stripe bank arbiter between the HDMI receiver
// and the stripe RAMs, with sticky overflow/line/frame error flags.
module hdmi_stripe_sched
   import hdmi_blk_pkg::*;
#(
   parameter int  N     = 2,
   parameter int  X_RES = 2160,
   parameter int  Y_RES = 1200,
   localparam int AW    = $clog2(8 * X_RES / N)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          hdmi_v_sync,
   input  logic          hdmi_h_sync,
   input  logic          hdmi_data_valid,
   output logic          wr_en,
   output logic          wr_bank,
   output logic [AW-1:0] wr_addr,
   output logic          rd_en,
   output logic          rd_bank,
   output logic [AW-1:0] rd_addr,
   input  logic          blk_ready,
   output logic          blk_valid,
   output logic          blk_sob,
   output logic          blk_eob,
   output logic          blk_sof,
   output logic          err_ovf,
   output logic          err_line,
   output logic          err_frame,
   input  logic          err_clr
);

   localparam int XB   = X_RES / N;
   localparam int NSTR = Y_RES / BLK_DIM;
   localparam int XW   = (XB > 1) ? $clog2(XB) : 1;
   localparam int SW   = (NSTR > 1) ? $clog2(NSTR) : 1;

   wr_state_t     w_st, w_nx;
   rd_state_t     r_st, r_nx;
   bank_state_t   bank_st [2];
   logic [1:0]    bank_first;
   logic          oldest;
   logic [XW-1:0] x, x_nx;
   logic [2:0]    line, line_nx;
   logic [SW-1:0] stripe, stripe_nx;
   logic          wb, wb_nx, rb, rb_nx;
   logic          vs_d, hs_d, v_rise, h_rise;
   logic          claim_en, claim_first, complete_en;
   logic          ovf_set, line_set, frame_set;
   logic          try_claim, try_first, tgt, line_done, stripe_done;
   logic          start_en, start_bank, release_en, sel, last_issue;

   assign v_rise  = hdmi_v_sync & ~vs_d;
   assign h_rise  = hdmi_h_sync & ~hs_d;
   assign wr_en   = en & hdmi_data_valid & (w_st == W_FILL);
   assign wr_addr = AW'(int'(line) * XB + int'(x));
   assign wr_bank = wb;
   assign rd_bank = rb;

   // Write side: raster counters, stripe completion and bank claiming.
   // A frame restart while filling keeps the bank it already owns.
   always_comb begin
      w_nx = w_st; x_nx = x; line_nx = line; stripe_nx = stripe; wb_nx = wb;
      claim_en = 1'b0; claim_first = 1'b0; complete_en = 1'b0;
      ovf_set = 1'b0; line_set = 1'b0; frame_set = 1'b0;
      try_claim = 1'b0; try_first = 1'b0; tgt = wb;
      line_done = 1'b0; stripe_done = 1'b0;
      case (w_st)
         W_IDLE: begin
            if (v_rise) begin
               try_claim = 1'b1; try_first = 1'b1;
               x_nx = '0; line_nx = '0; stripe_nx = '0;
            end
         end
         default: begin
            if (v_rise && (x != '0 || line != '0 || stripe != '0)) begin
               frame_set = 1'b1; try_claim = 1'b1; try_first = 1'b1;
               x_nx = '0; line_nx = '0; stripe_nx = '0;
            end else begin
               if (h_rise && x != '0) begin
                  line_set = 1'b1; x_nx = '0; line_done = 1'b1;
               end else if (hdmi_data_valid) begin
                  if (int'(x) == XB - 1) begin
                     x_nx = '0; line_done = 1'b1;
                  end else begin
                     x_nx = x + 1'b1;
                  end
               end
               if (line_done) begin
                  stripe_done = (line == 3'd7);
                  line_nx     = line + 3'd1;
               end
               if (stripe_done) begin
                  complete_en = (w_st == W_FILL);
                  tgt         = (w_st == W_FILL) ? ~wb : wb;
                  if (int'(stripe) == NSTR - 1) begin
                     stripe_nx = '0; w_nx = W_IDLE; wb_nx = tgt;
                  end else begin
                     stripe_nx = stripe + 1'b1; try_claim = 1'b1;
                  end
               end
            end
         end
      endcase
      if (try_claim) begin
         wb_nx = tgt;
         if (bank_st[tgt] == EMPTY || (w_st == W_FILL && tgt == wb)) begin
            w_nx = W_FILL; claim_en = 1'b1; claim_first = try_first;
         end else begin
            w_nx = W_DROP; ovf_set = 1'b1;
         end
      end
   end

   // Read side: take the oldest FULL bank, chain straight onto the other on release.
   always_comb begin
      r_nx = r_st; rb_nx = rb; start_en = 1'b0; start_bank = rb; release_en = 1'b0;
      sel = (bank_st[0] == FULL && bank_st[1] == FULL) ? oldest : (bank_st[1] == FULL);
      case (r_st)
         R_IDLE: begin
            if (bank_st[0] == FULL || bank_st[1] == FULL) begin
               r_nx = R_RUN; start_en = 1'b1; start_bank = sel; rb_nx = sel;
            end
         end
         default: begin
            if (last_issue) begin
               release_en = 1'b1;
               if (bank_st[~rb] == FULL) begin
                  start_en = 1'b1; start_bank = ~rb; rb_nx = ~rb;
               end else begin
                  r_nx = R_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_st <= W_IDLE; r_st <= R_IDLE;
         x <= '0; line <= '0; stripe <= '0; wb <= 1'b0; rb <= 1'b0;
         vs_d <= 1'b0; hs_d <= 1'b0;
         err_ovf <= 1'b0; err_line <= 1'b0; err_frame <= 1'b0;
      end else if (en) begin
         w_st <= w_nx; r_st <= r_nx;
         x <= x_nx; line <= line_nx; stripe <= stripe_nx; wb <= wb_nx; rb <= rb_nx;
         vs_d <= hdmi_v_sync; hs_d <= hdmi_h_sync;
         if (ovf_set) err_ovf <= 1'b1;
         else if (err_clr) err_ovf <= 1'b0;
         if (line_set) err_line <= 1'b1;
         else if (err_clr) err_line <= 1'b0;
         if (frame_set) err_frame <= 1'b1;
         else if (err_clr) err_frame <= 1'b0;
      end
   end

   // Write and read events always touch different banks, so they never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_st[0] <= EMPTY; bank_st[1] <= EMPTY;
         bank_first <= '0; oldest <= 1'b0;
      end else if (en) begin
         if (claim_en) begin
            bank_st[wb_nx]    <= FILLING;
            bank_first[wb_nx] <= claim_first;
         end
         if (complete_en) begin
            bank_st[wb] <= FULL;
            if (bank_st[~wb] != FULL) oldest <= wb;
         end
         if (release_en) bank_st[rb] <= EMPTY;
         if (start_en) bank_st[start_bank] <= READING;
      end
   end

   hdmi_stripe_rd_seq #(.N(N), .X_RES(X_RES), .AW(AW)) u_rd_seq (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .run        (r_st == R_RUN),
      .blk_ready  (blk_ready),
      .first      (bank_first[rb]),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .last_issue (last_issue),
      .blk_valid  (blk_valid),
      .blk_sob    (blk_sob),
      .blk_eob    (blk_eob),
      .blk_sof    (blk_sof)
   );

endmodule

// File: tb/tb_hdmi_stripe_sched.sv
// Directed bench for hdmi_stripe_sched at X_RES=32, Y_RES=16, N=2 (16 beats/line, 7-bit addresses).
`timescale 1ns/1ps
module tb_hdmi_stripe_sched;

   localparam int N = 2, X_RES = 32, Y_RES = 16, AW = 7;

   logic clk = 1'b0, rst = 1'b1, en = 1'b1;
   logic hdmi_v_sync = 1'b0, hdmi_h_sync = 1'b0, hdmi_data_valid = 1'b0;
   logic blk_ready = 1'b1, err_clr = 1'b0;
   logic wr_en, wr_bank, rd_en, rd_bank;
   logic [AW-1:0] wr_addr, rd_addr;
   logic blk_valid, blk_sob, blk_eob, blk_sof, err_ovf, err_line, err_frame;

   int checkCount = 0, passCount = 0;
   logic [7:0] wrLog[$];
   logic [7:0] rdLog[$];
   logic [2:0] flagLog[$];

   hdmi_stripe_sched #(.N(N), .X_RES(X_RES), .Y_RES(Y_RES)) dut (
      .clk(clk), .rst(rst), .en(en),
      .hdmi_v_sync(hdmi_v_sync), .hdmi_h_sync(hdmi_h_sync), .hdmi_data_valid(hdmi_data_valid),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
      .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
      .blk_ready(blk_ready), .blk_valid(blk_valid), .blk_sob(blk_sob), .blk_eob(blk_eob),
      .blk_sof(blk_sof), .err_ovf(err_ovf), .err_line(err_line), .err_frame(err_frame),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) wrLog.push_back({wr_bank, wr_addr});
      if (rd_en) rdLog.push_back({rd_bank, rd_addr});
      if (blk_valid) flagLog.push_back({blk_sof, blk_sob, blk_eob});
   end

   initial begin
      #1000000;
      $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic v, input logic h, input logic d, input int cycles);
      hdmi_v_sync = v; hdmi_h_sync = h; hdmi_data_valid = d;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic sendLine();
      applyStimulus(1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 16);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
   endtask

   task automatic sendFrame();
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      repeat (16) sendLine();
   endtask

   task automatic clearLogs();
      wrLog.delete(); rdLog.delete(); flagLog.delete();
   endtask

   // Two stripes of reads: bank 0 then bank 1, each stripe 4 blocks of 32 beats.
   task automatic checkBlockStream(input string tag);
      int rdErr = 0, sob = 0, eob = 0, sof = 0, misp = 0;
      checkOutput({tag, "_rd_count"}, 32'(rdLog.size()), 256);
      for (int k = 0; k < rdLog.size(); k++) begin
         int w = k % 128;
         int expv = ((k / 128) % 2) * 128 + ((w % 32) / 4) * 16 + (w / 32) * 4 + (w % 4);
         if (int'(rdLog[k]) != expv) rdErr++;
      end
      checkOutput({tag, "_rd_seq_errs"}, 32'(rdErr), 0);
      checkOutput({tag, "_valid_beats"}, 32'(flagLog.size()), 256);
      for (int j = 0; j < flagLog.size(); j++) begin
         logic [2:0] f = flagLog[j];
         sob += int'(f[1]); eob += int'(f[0]); sof += int'(f[2]);
         if (f[1] != (j % 32 == 0) || f[0] != (j % 32 == 31) || f[2] != (j == 0)) misp++;
      end
      checkOutput({tag, "_sob_count"}, 32'(sob), 8);
      checkOutput({tag, "_eob_count"}, 32'(eob), 8);
      checkOutput({tag, "_sof_count"}, 32'(sof), 1);
      checkOutput({tag, "_flag_misplaced"}, 32'(misp), 0);
   endtask

   task automatic checkWriteStream(input string tag);
      int wrErr = 0;
      checkOutput({tag, "_wr_count"}, 32'(wrLog.size()), 256);
      for (int k = 0; k < wrLog.size(); k++)
         if (int'(wrLog[k]) != k) wrErr++;
      checkOutput({tag, "_wr_seq_errs"}, 32'(wrErr), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset asserted in the middle of a line with a sticky error pending
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 10);
      applyStimulus(1'b0, 1'b1, 1'b0, 1);
      checkOutput("pre_rst_err_line", 32'(err_line), 1);
      hdmi_h_sync = 1'b0; hdmi_data_valid = 1'b1; #1;
      checkOutput("pre_rst_wr_en", 32'(wr_en), 1);
      rst = 1'b1; #1;
      checkOutput("rst_outputs", 32'({wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr, blk_valid,
                                     blk_sob, blk_eob, blk_sof, err_ovf, err_line, err_frame}), 0);
      @(posedge clk); #1 rst = 1'b0; hdmi_data_valid = 1'b0;
      @(posedge clk); #1;

      // Full frame, continuous valid and ready
      clearLogs();
      blk_ready = 1'b1;
      sendFrame();
      applyStimulus(1'b0, 1'b0, 1'b0, 250);
      checkOutput("wr_first", (wrLog.size() > 0) ? 32'(wrLog[0]) : 32'hFFFF, 0);
      checkWriteStream("frame");
      checkBlockStream("frame");
      checkOutput("rd_addr_4", (rdLog.size() > 4) ? 32'(rdLog[4]) : 32'hFFFF, 16);
      checkOutput("rd_addr_31", (rdLog.size() > 31) ? 32'(rdLog[31]) : 32'hFFFF, 115);
      checkOutput("rd_addr_32", (rdLog.size() > 32) ? 32'(rdLog[32]) : 32'hFFFF, 4);
      checkOutput("rd_bank1_start", (rdLog.size() > 128) ? 32'(rdLog[128]) : 32'hFFFF, 128);
      checkOutput("frame_no_errors", 32'({err_ovf, err_line, err_frame}), 0);

      // Early h_sync at x=10, en-low hold, then resume on line 1
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 10);
      applyStimulus(1'b0, 1'b1, 1'b0, 1);
      checkOutput("line_err_set", 32'(err_line), 1);
      checkOutput("line_err_no_frame_err", 32'(err_frame), 0);
      hdmi_h_sync = 1'b0; hdmi_data_valid = 1'b1; en = 1'b0; #1;
      checkOutput("en_low_wr_en", 32'(wr_en), 0);
      @(posedge clk); #1 en = 1'b1; #1;
      checkOutput("line_err_addr", 32'(wr_addr), 16);
      checkOutput("line_err_wr_en", 32'(wr_en), 1);
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 1'b1, 15);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      sendLine();
      applyStimulus(1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 5);

      // v_sync on line 3 of stripe 0 restarts the frame on bank 0
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput("frame_err_set", 32'(err_frame), 1);
      clearLogs();
      hdmi_v_sync = 1'b0; hdmi_data_valid = 1'b1; #1;
      checkOutput("frame_restart_addr", 32'({wr_bank, wr_addr}), 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 16);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      repeat (15) sendLine();
      applyStimulus(1'b0, 1'b0, 1'b0, 250);
      checkWriteStream("restart");
      checkBlockStream("restart");
      checkOutput("line_err_sticky", 32'(err_line), 1);
      err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      checkOutput("err_clr_all", 32'({err_ovf, err_line, err_frame}), 0);

      // Stalled reader: two stripes fill both banks, next frame is dropped
      blk_ready = 1'b0;
      sendFrame();
      checkOutput("ovf_not_yet", 32'(err_ovf), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      clearLogs();
      repeat (8) sendLine();
      checkOutput("drop_wr_count", 32'(wrLog.size()), 0);
      checkOutput("ovf_set", 32'(err_ovf), 1);
      repeat (8) sendLine();
      checkOutput("drop_rd_count", 32'(rdLog.size()), 0);
      err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      checkOutput("ovf_cleared", 32'(err_ovf), 0);

      // Drain both banks with blk_ready toggling every cycle
      clearLogs();
      for (int i = 0; i < 700; i++) begin
         blk_ready = i[0];
         applyStimulus(1'b0, 1'b0, 1'b0, 1);
      end
      blk_ready = 1'b1;
      checkBlockStream("toggle");
      checkOutput("toggle_wr_count", 32'(wrLog.size()), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/hdmi_stripe_sched.md
Name: hdmi_stripe_sched

Overview:
Controller that sequences the HDMI-to-block path: tracks raster position from HDMI sync/valid, and steers writes into a ping-pong pair of 8-line stripe buffers. It schedules block-order reads (8x8 blocks, N pixels per beat) once a stripe bank is full, and generates blk_sob/blk_eob/blk_sof. It sits between the HDMI receiver and the stripe RAMs/level-shift datapath and owns bank arbitration and overflow/sync error detection.

Parameters:
N, 2, pixels per beat (power of 2, ≤8)
X_RES, 2160, active pixels per line (multiple of 8)
Y_RES, 1200, active lines per frame (multiple of 8)
AW, $clog2(8*X_RES/N), bank address width (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
en  in  1  global enable; when low all state holds
hdmi_v_sync  in  1  frame sync, rising edge = start of frame
hdmi_h_sync  in  1  line sync, rising edge = start of line
hdmi_data_valid  in  1  one beat of N pixels present
wr_en  out  1  stripe RAM write strobe (combinational from valid and state)
wr_bank  out  1  bank written
wr_addr  out  AW  write address = line*(X_RES/N) + xbeat
rd_en  out  1  stripe RAM read strobe
rd_bank  out  1  bank read
rd_addr  out  AW  read address = row*(X_RES/N) + blk*(8/N) + col
blk_ready  in  1  downstream can accept a beat
blk_valid  out  1  RAM read data valid (rd_en delayed 1 cycle)
blk_sob  out  1  first beat of block, aligned with blk_valid
blk_eob  out  1  last (64/N-th) beat of block
blk_sof  out  1  with blk_sob on first block of stripe 0
err_ovf  out  1  sticky: stripe dropped, no free bank
err_line  out  1  sticky: h_sync before line complete
err_frame  out  1  sticky: v_sync mid-frame
err_clr  in  1  clears all sticky errors (lower priority than setting)

Behaviour:
- Reset: all outputs 0, counters 0, both banks EMPTY, write FSM W_IDLE, read FSM R_IDLE.
- en low: no state change; wr_en, rd_en forced 0; blk_valid 0 the next cycle.
- Bank state per bank: EMPTY -> FILLING -> FULL -> READING -> EMPTY; each bank carries a first-stripe tag for sof.
- Write FSM: W_IDLE waits for v_sync rising edge -> W_FILL on bank 0, x=y=0, tag set. Each valid beat: wr_en=1, x++; x wraps at X_RES/N-1, line++. At the last beat of line 7, bank goes FULL next cycle; the next stripe claims the other bank. If that bank is not EMPTY, go to W_DROP: wr_en=0 and err_ovf set. This stripe's 8 lines are discarded, then a bank is retried. After stripe Y_RES/8-1, return to W_IDLE.
- h_sync rising with x≠0: err_line set, x=0, line++ (partial line keeps its written data).
- v_sync rising when not W_IDLE and (x≠0 or stripe/line≠0): err_frame set, FILLING bank returned to EMPTY, restart at bank-select of next EMPTY bank with the first-stripe tag.
- Read FSM: R_IDLE -> R_RUN when any bank FULL (oldest first); bank -> READING. Counters col (0..8/N-1), row (0..7), blk (0..X_RES/8-1). rd_en = R_RUN && blk_ready && en; counters advance only on rd_en.
- Latency: blk_valid/sob/eob/sof = rd_en-stage flags registered 1 cycle (matches 1-cycle RAM). Downstream must accept the beat in flight after dropping blk_ready.
- Last beat of last block issued: bank EMPTY the next cycle; R_IDLE or immediately R_RUN on the other FULL bank the same cycle.
- Simultaneous write-complete and read-release on different banks: both apply in the same cycle.
- Write-claim sees a release only one cycle later.

Decomposition:
- Package hdmi_blk_pkg: BLK_DIM=8, bank_state_t enum {EMPTY,FILLING,FULL,READING}, wr_state_t, rd_state_t, beats-per-block function.
- Sub-module hdmi_stripe_rd_seq: col/row/blk counters, rd_addr, sob/eob/sof generation, 1-cycle flag pipeline.

Test Plan:
- Reset (X_RES=32,Y_RES=16,N=2): rst=1 mid-activity -> all outputs 0 immediately, first write after v_sync is bank 0 addr 0.
- Full frame, valid=1, blk_ready=1: wr_addr 0..127 bank0 then bank1. Block0 rd_addr 0,1,2,3,16,17,18,19,...,112..115. Totals: 8 sob, 8 eob each 32 beats after its sob, 1 sof.
- blk_ready=0 for 3 stripes (Y_RES=24): stripe 2 dropped -> wr_en low for 128 valid beats, err_ovf=1; err_clr -> 0.
- h_sync rising at x=10 on line 0 -> err_line=1, next valid beat wr_addr=16.
- v_sync at line 3 stripe 0 -> err_frame=1, bank0 EMPTY, next beat wr_addr 0; first block read afterwards carries blk_sof.
- blk_ready toggling every cycle -> rd_addr sequence identical to continuous case, 32 blk_valid beats per block, no loss/duplication.
